// File: rtl/adsr_pkg.sv
// Shared state encoding, width defaults and level helpers for the ADSR
// envelope generator and its VCA.
package adsr_pkg;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_ENV_W    = 16;
    localparam int DEF_STEP_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    // Full-scale envelope level for an envelope of the given width (width < 32).
    function automatic int unsigned env_max(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/adsr_vca.sv
// Envelope-controlled amplifier: signed sample times unsigned level, floor
// shifted back to sample width and registered with a one-clock valid strobe.
module adsr_vca
    import adsr_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int ENV_W    = DEF_ENV_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_ready,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [ENV_W-1:0]    env,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                out_ready
);
    localparam int PROD_W = SAMPLE_W + ENV_W + 1;

    logic signed [PROD_W-1:0]   w_prod_p0;
    logic signed [SAMPLE_W-1:0] w_scaled_p0;
    logic signed [SAMPLE_W-1:0] r_sample_p1;
    logic                       r_vld_p1;

    // The zero-extended level keeps the product signed; the result always fits SAMPLE_W.
    assign w_prod_p0   = $signed(sample_in) * $signed({1'b0, env});
    assign w_scaled_p0 = SAMPLE_W'(w_prod_p0 >>> ENV_W);

    // Stage p0 -> p1: register scaled sample, hold it between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample_p1 <= '0;
            r_vld_p1    <= 1'b0;
        end else begin
            r_vld_p1 <= in_ready;
            if (in_ready) begin
                r_sample_p1 <= w_scaled_p0;
            end
        end
    end

    assign sample_out = r_sample_p1;
    assign out_ready  = r_vld_p1;

endmodule

// File: rtl/adsr_env_gen.sv
// Gated ADSR envelope generator with programmable step sizes and sustain
// level, advancing once per sample strobe and driving an integrated VCA.
module adsr_env_gen
    import adsr_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int ENV_W    = DEF_ENV_W,
    parameter int STEP_W   = DEF_STEP_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                gate,
    input  logic                in_ready,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [STEP_W-1:0]   attack_step,
    input  logic [STEP_W-1:0]   decay_step,
    input  logic [ENV_W-1:0]    sustain_level,
    input  logic [STEP_W-1:0]   release_step,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                out_ready,
    output logic [ENV_W-1:0]    env_level,
    output logic                active
);
    localparam int               EXT_W   = ENV_W + 1;
    localparam logic [ENV_W-1:0] ENV_MAX = ENV_W'(env_max(ENV_W));

    adsr_state_t      r_state;
    logic [ENV_W-1:0] r_env;
    logic             r_gate_q;

    logic             w_rise;
    logic             w_fall;
    adsr_state_t      w_state_edge;
    logic [EXT_W-1:0] w_env_ext;
    logic [EXT_W-1:0] w_att_sum;
    logic [EXT_W-1:0] w_dec_floor;
    logic [EXT_W-1:0] w_rel_ext;
    logic [ENV_W-1:0] w_dec_diff;
    logic [ENV_W-1:0] w_rel_diff;

    assign w_rise = gate & ~r_gate_q;
    assign w_fall = ~gate & r_gate_q;

    // Gate edges resolve first; a coincident strobe then uses the new state's rule.
    always_comb begin
        w_state_edge = r_state;
        if (w_rise) begin
            w_state_edge = ST_ATTACK;
        end else if (w_fall && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                                r_state == ST_SUSTAIN)) begin
            w_state_edge = ST_RELEASE;
        end
    end

    // One extra bit lets saturation be detected without wrap.
    assign w_env_ext   = {1'b0, r_env};
    assign w_att_sum   = w_env_ext + EXT_W'(attack_step);
    assign w_dec_floor = {1'b0, sustain_level} + EXT_W'(decay_step);
    assign w_rel_ext   = EXT_W'(release_step);
    assign w_dec_diff  = r_env - ENV_W'(decay_step);
    assign w_rel_diff  = r_env - ENV_W'(release_step);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_env    <= '0;
            r_gate_q <= 1'b0;
        end else begin
            r_gate_q <= gate;
            r_state  <= w_state_edge;
            if (in_ready) begin
                case (w_state_edge)
                    ST_ATTACK: begin
                        if (attack_step == '0 || w_att_sum >= {1'b0, ENV_MAX}) begin
                            r_env   <= ENV_MAX;
                            r_state <= ST_DECAY;
                        end else begin
                            r_env <= w_att_sum[ENV_W-1:0];
                        end
                    end
                    ST_DECAY: begin
                        if (decay_step == '0 || w_env_ext <= w_dec_floor) begin
                            r_env   <= sustain_level;
                            r_state <= ST_SUSTAIN;
                        end else begin
                            r_env <= w_dec_diff;
                        end
                    end
                    ST_SUSTAIN: begin
                        r_env <= sustain_level;
                    end
                    ST_RELEASE: begin
                        if (release_step == '0 || w_env_ext <= w_rel_ext) begin
                            r_env   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_env <= w_rel_diff;
                        end
                    end
                    default: begin
                        r_env   <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign env_level = r_env;
    assign active    = (r_state != ST_IDLE);

    // The VCA scales by the level held before this strobe's update.
    adsr_vca #(
        .SAMPLE_W (SAMPLE_W),
        .ENV_W    (ENV_W)
    ) u_vca (
        .clk        (clk),
        .reset      (reset),
        .in_ready   (in_ready),
        .sample_in  (sample_in),
        .env        (r_env),
        .sample_out (sample_out),
        .out_ready  (out_ready)
    );

endmodule

// File: tb/tb_adsr_env_gen.sv
// Self-checking bench for adsr_env_gen: directed scenarios plus randomized
// stimulus, all compared against a behavioural envelope/VCA model.
module tb_adsr_env_gen;

    localparam int ENV_MAX = 65535;
    localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        gate;
    logic        in_ready;
    logic [15:0] sample_in;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] sustain_level;
    logic [15:0] release_step;
    logic [15:0] sample_out;
    logic        out_ready;
    logic [15:0] env_level;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state  = M_IDLE;
    int m_env    = 0;
    bit m_gate_q = 1'b0;
    int m_sample = 0;
    bit m_out_ready = 1'b0;

    adsr_env_gen #(
        .SAMPLE_W (16),
        .ENV_W    (16),
        .STEP_W   (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .gate          (gate),
        .in_ready      (in_ready),
        .sample_in     (sample_in),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .sample_out    (sample_out),
        .out_ready     (out_ready),
        .env_level     (env_level),
        .active        (active)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, observed no end of test, required end of test");
        $fatal(1, "bench stopped by time limit");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Signed sample times level divided by 2^16, rounded toward minus infinity.
    function automatic int vca_ref(input logic [15:0] smp, input int env);
        longint p;
        longint q;
        p = longint'($signed(smp)) * longint'(env);
        q = p / 65536;
        if (p < 0 && (p % 65536) != 0) q = q - 1;
        return int'(q);
    endfunction

    task automatic model_reset();
        m_state     = M_IDLE;
        m_env       = 0;
        m_gate_q    = 1'b0;
        m_sample    = 0;
        m_out_ready = 1'b0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_clock();
        bit rise;
        bit fall;
        int att;
        int dec;
        int rel;
        int sus;
        rise = gate && !m_gate_q;
        fall = !gate && m_gate_q;
        att  = int'(attack_step);
        dec  = int'(decay_step);
        rel  = int'(release_step);
        sus  = int'(sustain_level);
        m_out_ready = in_ready;
        if (in_ready) m_sample = vca_ref(sample_in, m_env);
        if (rise) m_state = M_ATT;
        else if (fall && (m_state == M_ATT || m_state == M_DEC || m_state == M_SUS)) m_state = M_REL;
        if (in_ready) begin
            if (m_state == M_ATT) begin
                if (att == 0 || m_env + att >= ENV_MAX) begin
                    m_env = ENV_MAX;
                    m_state = M_DEC;
                end else m_env = m_env + att;
            end else if (m_state == M_DEC) begin
                if (dec == 0 || m_env - dec <= sus) begin
                    m_env = sus;
                    m_state = M_SUS;
                end else m_env = m_env - dec;
            end else if (m_state == M_SUS) begin
                m_env = sus;
            end else if (m_state == M_REL) begin
                if (rel == 0 || m_env <= rel) begin
                    m_env = 0;
                    m_state = M_IDLE;
                end else m_env = m_env - rel;
            end else begin
                m_env = 0;
            end
        end
        m_gate_q = gate;
    endtask

    task automatic compare_outputs();
        check_val("env_level", 32'(env_level), 32'(m_env));
        check_val("active", 32'(active), 32'(m_state != M_IDLE));
        check_val("out_ready", 32'(out_ready), 32'(m_out_ready));
        check_val("sample_out", 32'(sample_out), 32'(m_sample) & 32'h0000_FFFF);
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
    endtask

    // One idle clock then one strobed clock with a random sample.
    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            in_ready = 1'b0;
            cycle();
            in_ready  = 1'b1;
            sample_in = 16'($urandom);
            cycle();
        end
        in_ready = 1'b0;
    endtask

    function automatic logic [15:0] rand_step();
        case ($urandom_range(4))
            0:       return 16'h0000;
            1:       return 16'($urandom_range(16'h0400, 16'h0010));
            2:       return 16'($urandom_range(16'hFFFF, 16'hF000));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b0; gate = 1'b0; in_ready = 1'b0; sample_in = '0;
        attack_step = '0; decay_step = '0; sustain_level = '0; release_step = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_env", 32'(env_level), 32'h0);
        check_val("rst_sample", 32'(sample_out), 32'h0);
        check_val("rst_out_ready", 32'(out_ready), 32'h0);
        check_val("rst_active", 32'(active), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Attack ramp into decay and sustain.
        attack_step = 16'h4000; decay_step = 16'h1000;
        sustain_level = 16'h8000; release_step = 16'h3000;
        gate = 1'b1;
        cycle();
        strobes(4);
        check_val("att_peak", 32'(env_level), 32'hFFFF);
        strobes(8);
        check_val("sus_level", 32'(env_level), 32'h8000);
        strobes(2);

        // VCA with half-scale level.
        in_ready = 1'b1; sample_in = 16'h7FFF;
        cycle();
        check_val("vca_half", 32'(sample_out), 32'h3FFF);
        check_val("vca_strobe", 32'(out_ready), 32'h1);
        in_ready = 1'b0;
        cycle();

        // Release to idle.
        gate = 1'b0;
        cycle();
        strobes(3);
        check_val("rel_env", 32'(env_level), 32'h0);
        check_val("rel_active", 32'(active), 32'h0);
        strobes(2);
        check_val("idle_sample", 32'(sample_out), 32'h0);

        // Instant attack/decay, then instant release.
        attack_step = 16'h0; decay_step = 16'h0; sustain_level = 16'h8000;
        gate = 1'b1;
        cycle();
        in_ready = 1'b1; sample_in = 16'h1234;
        cycle();
        check_val("inst_att", 32'(env_level), 32'hFFFF);
        sample_in = 16'h8000;
        cycle();
        check_val("vca_fullneg", 32'(sample_out), 32'h8000);
        check_val("inst_dec", 32'(env_level), 32'h8000);
        in_ready = 1'b0;
        release_step = 16'h0; gate = 1'b0;
        cycle();
        in_ready = 1'b1;
        cycle();
        check_val("inst_rel", 32'(env_level), 32'h0);
        in_ready = 1'b0;
        cycle();

        // Retrigger from release on a coincident strobe.
        release_step = 16'h3000; gate = 1'b1;
        cycle();
        in_ready = 1'b1;
        cycle();
        cycle();
        in_ready = 1'b0; gate = 1'b0;
        cycle();
        in_ready = 1'b1;
        cycle();
        check_val("rel_step", 32'(env_level), 32'h5000);
        attack_step = 16'h1000; gate = 1'b1;
        cycle();
        check_val("retrig_env", 32'(env_level), 32'h6000);
        check_val("retrig_active", 32'(active), 32'h1);

        // Asynchronous reset between edges while in attack.
        sample_in = 16'h4321;
        model_clock();
        @(posedge clk);
        #1;
        compare_outputs();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_val("arst_env", 32'(env_level), 32'h0);
        check_val("arst_sample", 32'(sample_out), 32'h0);
        check_val("arst_out_ready", 32'(out_ready), 32'h0);
        check_val("arst_active", 32'(active), 32'h0);
        @(negedge clk);
        gate = 1'b0; in_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_in = 16'($urandom);
            cycle();
        end
        check_val("post_rst_sample", 32'(sample_out), 32'h0);
        in_ready = 1'b0;

        // Randomized operation with live parameter changes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 97 == 0) begin
                attack_step  = rand_step();
                decay_step   = rand_step();
                release_step = rand_step();
            end
            if ($urandom_range(31) == 0) sustain_level = 16'($urandom);
            if ($urandom_range(23) == 0) gate = ~gate;
            in_ready  = 1'($urandom_range(1));
            sample_in = 16'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adsr_env_gen.md
Name: adsr_env_gen

Overview:
Parametrised successor to the fixed-envelope adsr block. It is a gated ADSR envelope generator with programmable attack, decay and release step sizes and a programmable sustain level, with an integrated VCA. The envelope advances once per sample strobe (in_ready). Each strobed input sample is scaled by the current envelope and emitted one clock later with a valid strobe. It sits between the oscillator/wavetable output and the mixer/codec path.

Parameters:
SAMPLE_W, 16, signed audio sample width (in and out)
ENV_W, 16, unsigned envelope level width; ENV_MAX = 2^ENV_W-1
STEP_W, 16, width of the attack/decay/release step inputs (STEP_W <= ENV_W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
gate  in  1  note-on level; rise = trigger, fall = release
in_ready  in  1  one-cycle sample strobe; sample_in valid on this cycle
sample_in  in  SAMPLE_W  signed input sample
attack_step  in  STEP_W  envelope increment per strobe in ATTACK; 0 = instant
decay_step  in  STEP_W  decrement per strobe in DECAY; 0 = instant
sustain_level  in  ENV_W  sustain target level
release_step  in  STEP_W  decrement per strobe in RELEASE; 0 = instant
sample_out  out  SAMPLE_W  signed scaled sample, registered
out_ready  out  1  one-cycle strobe, sample_out valid
env_level  out  ENV_W  current envelope level
active  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, async): state=IDLE, env_level=0, sample_out=0, out_ready=0, gate_q=0. Releasing reset mid-note leaves the block in IDLE; a new gate rise is required.
- Gate edge detection uses registered gate_q. rise = gate & ~gate_q. fall = ~gate & gate_q. Edges act on the clock they are seen, independent of in_ready.
- rise in any state -> ATTACK. env_level is kept (legato retrigger from current level, no snap to 0).
- fall in ATTACK/DECAY/SUSTAIN -> RELEASE. fall in IDLE/RELEASE: no effect.
- Envelope arithmetic occurs only on clocks with in_ready=1. It uses (ENV_W+1)-bit intermediates and saturates; no wrap.
- ATTACK: env+attack_step >= ENV_MAX, or attack_step=0 -> env=ENV_MAX, state=DECAY. Otherwise env += attack_step.
- DECAY: env-decay_step <= sustain_level, or decay_step=0 -> env=sustain_level, state=SUSTAIN. Otherwise env -= decay_step.
- SUSTAIN: env=sustain_level on each strobe. This tracks live changes to sustain_level.
- RELEASE: env <= release_step, or release_step=0 -> env=0, state=IDLE. Otherwise env -= release_step.
- IDLE: env held at 0.
- Simultaneous edge and in_ready on the same clock: the edge-driven transition takes precedence. The arithmetic for that strobe uses the new state's rule. Example: rise with in_ready in RELEASE applies the ATTACK increment.
- Step and level inputs are sampled live; there is no latching.
- VCA: on an in_ready clock, product = sample_in (signed) * {1'b0, env_level before this strobe's update}. sample_out <= product >>> ENV_W (arithmetic shift, floor). out_ready <= 1 on the next clock. Latency is exactly 1 clock from in_ready to out_ready.
- sample_out holds its value between strobes. out_ready is high for exactly one clock per in_ready.
- in_ready on consecutive clocks is legal; each strobe produces its own out_ready.
- State encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Decomposition:
- Package adsr_pkg: state enum/localparams (IDLE..RELEASE), ENV_MAX derivation function, default widths.
- Sub-module adsr_vca handles the signed x unsigned multiply, shift and output register (sample_in, env, in_ready -> sample_out, out_ready).
- The FSM and envelope saturation logic stay in adsr_env_gen.

Test Plan:
- Attack ramp: reset released, attack_step=0x4000, decay_step=0x1000, sustain_level=0x8000, gate rise, in_ready every 2nd clock -> env_level 0x4000, 0x8000, 0xC000, 0xFFFF (state DECAY), then 0xEFFF, 0xDFFF ... down to 0x8000 with state SUSTAIN.
- VCA math: sample_in=0x7FFF with env=0x8000 -> sample_out=0x3FFF one clock later with out_ready pulse. sample_in=0x8000 with env=0xFFFF -> sample_out=0x8000.
- Release: in SUSTAIN at 0x8000, release_step=0x3000, gate fall -> env 0x5000, 0x2000, 0x0000; then IDLE and active=0. Further strobes output 0.
- Instant modes: attack_step=0, decay_step=0 -> first strobe env=0xFFFF, second strobe env=sustain_level and state SUSTAIN. release_step=0 -> env=0 on the first strobe after the fall.
- Retrigger and coincidence: gate rise in RELEASE at env=0x5000 on the same clock as in_ready with attack_step=0x1000 -> env=0x6000, state ATTACK.
- Async reset mid-ATTACK: reset asserted between clock edges -> outputs and env go to 0 immediately. After release, strobes give sample_out=0 until a new gate rise.
